// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays a refund back as single-cycle coin pulses,
// largest denomination first, limited by per-denomination coin stock.
module change_dispenser #(
  parameter int AMT_W      = 8,
  parameter int STOCK_W    = 6,
  parameter int INIT_STOCK = 8,
  parameter int GAP_CYC    = 1
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             refund_req,
  input  logic [AMT_W-1:0] refund_amt,
  input  logic             restock,
  output logic             busy,
  output logic [2:0]       coin_out,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remain_out
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {IDLE, PICK, EMIT, GAP, FINISH} state_t;

  state_t             state;
  logic [AMT_W-1:0]   remain;
  logic [GAP_W-1:0]   gap_cnt;
  logic [STOCK_W-1:0] stock [4];
  logic               found;
  logic [1:0]         pick_idx;

  // Index 0..3 maps to CNY_0p5, CNY_1, CNY_5, CNY_10; coin code is index+1.
  function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] idx);
    case (idx)
      2'd0:    coin_val = AMT_W'(1);
      2'd1:    coin_val = AMT_W'(2);
      2'd2:    coin_val = AMT_W'(10);
      default: coin_val = AMT_W'(20);
    endcase
  endfunction

  // Ascending scan so the largest eligible denomination wins.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (coin_val(2'(i)) <= remain && stock[i] != '0) begin
        found    = 1'b1;
        pick_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      coin_out   <= '0;
      done       <= 1'b0;
      short      <= 1'b0;
      remain_out <= '0;
      remain     <= '0;
      gap_cnt    <= '0;
      for (int unsigned i = 0; i < 4; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      case (state)
        IDLE: begin
          if (restock)
            for (int unsigned i = 0; i < 4; i++) stock[i] <= STOCK_W'(INIT_STOCK);
          if (refund_req) begin
            remain <= refund_amt;
            short  <= 1'b0;
            busy   <= 1'b1;
            state  <= PICK;
          end
        end
        PICK: begin
          if (remain == '0 || !found) begin
            short      <= (remain != '0);
            done       <= 1'b1;
            remain_out <= remain;
            state      <= FINISH;
          end else begin
            coin_out        <= 3'(pick_idx) + 3'd1;
            remain          <= remain - coin_val(pick_idx);
            stock[pick_idx] <= stock[pick_idx] - STOCK_W'(1);
            state           <= EMIT;
          end
        end
        EMIT: begin
          coin_out <= '0;
          gap_cnt  <= GAP_W'(GAP_CYC - 1);
          state    <= GAP;
        end
        GAP: begin
          if (gap_cnt == '0) state <= PICK;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random traffic, checked
// every cycle against a greedy plan/schedule model.
module tb_change_dispenser;

  localparam int AMT_W      = 8;
  localparam int STOCK_W    = 6;
  localparam int INIT_STOCK = 8;
  localparam int GAP_CYC    = 1;
  localparam int PERIOD     = 2 + GAP_CYC;

  logic             rst, clk, refund_req, restock;
  logic [AMT_W-1:0] refund_amt;
  logic             busy, done, short;
  logic [2:0]       coin_out;
  logic [AMT_W-1:0] remain_out;

  change_dispenser #(
    .AMT_W(AMT_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK), .GAP_CYC(GAP_CYC)
  ) dut (
    .rst(rst), .clk(clk), .refund_req(refund_req), .refund_amt(refund_amt),
    .restock(restock), .busy(busy), .coin_out(coin_out), .done(done),
    .short(short), .remain_out(remain_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: on acceptance, compute the whole greedy payout and its timetable.
  int val_of [4] = '{1, 2, 10, 20};
  int m_stock [4];
  int plan [$];
  int e = 0, kreq = -10, kend = -10;
  int plan_rem = 0, m_short = 0, m_remain = 0;
  bit plan_short = 0;
  int exp_busy, exp_coin, exp_done, exp_short, exp_remain;

  always @(posedge clk) begin
    e++;
    if (rst) begin
      kreq = -10; kend = -10; m_short = 0; m_remain = 0; plan.delete();
      for (int i = 0; i < 4; i++) m_stock[i] = INIT_STOCK;
    end else begin
      if (e > kend + 1) begin
        if (restock) for (int i = 0; i < 4; i++) m_stock[i] = INIT_STOCK;
        if (refund_req) begin
          int rem, d;
          rem = refund_amt; plan.delete(); plan_short = 0;
          while (rem > 0) begin
            d = -1;
            for (int i = 0; i < 4; i++)
              if (val_of[i] <= rem && m_stock[i] > 0) d = i;
            if (d < 0) begin plan_short = 1; break; end
            plan.push_back(d + 1);
            rem -= val_of[d];
            m_stock[d]--;
          end
          plan_rem = rem;
          kreq = e;
          kend = e + 1 + plan.size() * PERIOD;
          m_short = 0;
        end
      end
      if (e == kend) begin m_short = plan_short; m_remain = plan_rem; end
    end
    exp_busy = (e >= kreq && e <= kend);
    exp_done = (e == kend);
    exp_coin = 0;
    if (exp_busy && e > kreq) begin
      int j;
      j = e - kreq - 1;
      if (j % PERIOD == 0 && j / PERIOD < plan.size()) exp_coin = plan[j / PERIOD];
    end
    exp_short = m_short;
    exp_remain = m_remain;
  end

  bit checking = 0;
  int cap [$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (checking) begin
      check("busy", busy, exp_busy);
      check("coin_out", coin_out, exp_coin);
      check("done", done, exp_done);
      check("short", short, exp_short);
      check("remain_out", remain_out, exp_remain);
    end
    if (coin_out != 0) cap.push_back(coin_out);
    if (done) done_cnt++;
  end

  task automatic req(input int amt);
    refund_req = 1; refund_amt = AMT_W'(amt);
    @(negedge clk);
    refund_req = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check({name, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; @(negedge clk); rst = 0;
  endtask

  initial begin
    int exp1 [5] = '{4, 2, 2, 2, 1};
    int dc0;
    rst = 1; refund_req = 0; restock = 0; refund_amt = '0;
    @(negedge clk);
    checking = 1;
    @(negedge clk);
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_coin", coin_out, 0);
    check("rst_done", done, 0);
    check("rst_short", short, 0);
    check("rst_remain", remain_out, 0);

    // 1: 27 -> 10,1,1,1,0.5
    cap.delete();
    req(27); wait_idle("t1");
    check("t1_ncoins", cap.size(), 5);
    for (int i = 0; i < 5 && i < cap.size(); i++) check("t1_coin", cap[i], exp1[i]);
    check("t1_short", short, 0);
    check("t1_model_stock10", m_stock[3], 7);

    // 2: zero amount
    cap.delete(); dc0 = done_cnt;
    req(0); wait_idle("t2");
    check("t2_ncoins", cap.size(), 0);
    check("t2_done", done_cnt - dc0, 1);
    check("t2_short", short, 0);
    check("t2_remain", remain_out, 0);

    // 3: drain CNY_0p5, then short, then restock
    do_reset();
    for (int i = 0; i < 8; i++) begin req(1); wait_idle("t3a"); end
    cap.delete();
    req(1); wait_idle("t3b");
    check("t3_ncoins", cap.size(), 0);
    check("t3_short", short, 1);
    check("t3_remain", remain_out, 1);
    restock = 1; @(negedge clk); restock = 0;
    cap.delete();
    req(1); wait_idle("t3c");
    check("t3_restock_ncoins", cap.size(), 1);
    if (cap.size() > 0) check("t3_restock_coin", cap[0], 1);
    check("t3_restock_short", short, 0);

    // 4: CNY_10 drained -> fall back to two CNY_5
    do_reset();
    for (int i = 0; i < 8; i++) begin req(20); wait_idle("t4a"); end
    cap.delete();
    req(20); wait_idle("t4b");
    check("t4_ncoins", cap.size(), 2);
    for (int i = 0; i < 2 && i < cap.size(); i++) check("t4_coin", cap[i], 3);
    check("t4_short", short, 0);

    // 5: request while busy is ignored
    do_reset();
    cap.delete(); dc0 = done_cnt;
    req(40); @(negedge clk); req(2); wait_idle("t5");
    check("t5_ncoins", cap.size(), 2);
    for (int i = 0; i < 2 && i < cap.size(); i++) check("t5_coin", cap[i], 4);
    check("t5_done", done_cnt - dc0, 1);

    // 6: reset after the first coin aborts
    do_reset();
    dc0 = done_cnt;
    req(27);
    begin
      int n;
      n = 0;
      while (coin_out == 0 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check("t6_timeout", 1, 0);
    end
    rst = 1; @(negedge clk); rst = 0;
    check("t6_busy", busy, 0);
    check("t6_coin", coin_out, 0);
    check("t6_done", done_cnt - dc0, 0);
    check("t6_model_stock10", m_stock[3], INIT_STOCK);
    cap.delete();
    req(27); wait_idle("t6b");
    check("t6_after_ncoins", cap.size(), 5);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      refund_req = ($urandom_range(0, 3) == 0);
      refund_amt = AMT_W'($urandom_range(0, 70));
      restock = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 150) == 0);
      @(negedge clk);
    end
    refund_req = 0; restock = 0; rst = 0;
    repeat (3) @(negedge clk);
    wait_idle("final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
